// File: rtl/pl_exc_store_buf.sv
// Store buffer sitting between the MEM stage and a single-port data memory.
// Queues stores, drains one word per cycle, and forwards pending store data
// to loads so memory is only read when no pending store hits the same word.
//
// Ports:
//   clk, clrn            clock, async active-low reset
//   cpu_we/cpu_re        store/load request from the MEM stage
//   cpu_addr/cpu_wdata   byte address (word-aligned) and store data
//   cpu_rdata            load data (combinational)
//   stall                request not accepted this cycle (combinational)
//   empty                no pending stores
//   mem_we/mem_addr/mem_wdata/mem_rdata  data-memory port
module pl_exc_store_buf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        empty,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] ent_waddr [DEPTH];
  logic [31:0]   ent_data  [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          full;
  logic          drain;
  logic          accept;
  logic [AW-1:0] cpu_waddr;

  assign cpu_waddr = cpu_addr[AW+1:2];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  // A full buffer must drain even while a load wants the port.
  assign drain     = ~empty & (full | ~cpu_re);
  assign stall     = full & (cpu_we | cpu_re);
  assign accept    = cpu_we & ~stall;

  // Memory address port arbitration.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = '0;
    if (drain) begin
      mem_we    = 1'b1;
      mem_addr  = 32'({ent_waddr[head], 2'b00});
      mem_wdata = ent_data[head];
    end
  end

  // Forwarding: walk oldest to newest so the last hit is the newest store.
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] idx;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (ent_waddr[idx] == cpu_waddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end

  assign cpu_rdata = (cpu_re & ~stall & fwd_hit) ? fwd_data : mem_rdata;

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_waddr[tail] <= cpu_waddr;
      ent_data[tail]  <= cpu_wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + PW'(1);
      if (drain)  head <= head + PW'(1);
      case ({accept, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pl_exc_store_buf.sv
// Directed bench for pl_exc_store_buf with a small word-addressed memory model.
module tb_pl_exc_store_buf;

  logic        clk = 1'b0;
  logic        clrn;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        empty;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        mem_init;
  logic [31:0] mem [0:63];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pl_exc_store_buf #(.DEPTH(4), .AW(5)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .empty     (empty),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory: combinational read, clocked write.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
      mem[21] <= 32'h5454_5454;  // word 0x54
      mem[23] <= 32'h0000_0115;  // word 0x5c
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs at the falling edge, settle, then callers sample.
  task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(negedge clk);
    cpu_we    = we;
    cpu_re    = re;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    #1;
  endtask

  initial begin
    clrn      = 1'b0;
    mem_init  = 1'b1;
    cpu_we    = 1'b0;
    cpu_re    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (2) @(negedge clk);
    clrn     = 1'b1;
    mem_init = 1'b0;

    // Idle after reset.
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    // Reset pulsed mid-drain discards the pending store.
    drive(1'b1, 1'b0, 32'h60, 32'h77);
    drive(1'b1, 1'b0, 32'h64, 32'h88);
    check("md_drain_addr", mem_addr, 32'h60);
    check("md_drain_data", mem_wdata, 32'h77);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("md_pend_we", 32'(mem_we), 32'd1);
    check("md_pend_addr", mem_addr, 32'h64);
    clrn = 1'b0;
    #1;
    check("md_rst_empty", 32'(empty), 32'd1);
    check("md_rst_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("md_after_we", 32'(mem_we), 32'd0);
    check("md_mem60", mem[24], 32'h77);
    check("md_mem64", mem[25], 32'h0);

    // Single store, drained next cycle.
    drive(1'b1, 1'b0, 32'h50, 32'h1111_1111);
    check("st_empty_before", 32'(empty), 32'd1);
    check("st_we_before", 32'(mem_we), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("st_mem_we", 32'(mem_we), 32'd1);
    check("st_mem_addr", mem_addr, 32'h50);
    check("st_mem_wdata", mem_wdata, 32'h1111_1111);
    check("st_not_empty", 32'(empty), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("st_empty_after", 32'(empty), 32'd1);
    check("st_mem50", mem[20], 32'h1111_1111);

    // Four stores under concurrent loads fill the buffer (no drain while loading).
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'h1000 + 32'(i));
      check("fill_stall", 32'(stall), 32'd0);
      check("fill_mem_we", 32'(mem_we), 32'd0);
      if (i == 1) check("fill_load_miss", cpu_rdata, 32'h0);
    end
    // Full: load stalls, buffer drains.
    drive(1'b0, 1'b1, 32'h54, 32'h0);
    check("full_ld_stall", 32'(stall), 32'd1);
    check("full_ld_mem_we", 32'(mem_we), 32'd1);
    check("full_ld_addr", mem_addr, 32'h40);
    check("full_ld_wdata", mem_wdata, 32'h1000);
    drive(1'b0, 1'b1, 32'h54, 32'h0);
    check("ld54_stall", 32'(stall), 32'd0);
    check("ld54_mem_we", 32'(mem_we), 32'd0);
    check("ld54_addr", mem_addr, 32'h54);
    check("ld54_rdata", cpu_rdata, 32'h5454_5454);

    // Refill to 4 (tail wraps to 0), then a store against a full buffer.
    drive(1'b1, 1'b1, 32'h70, 32'hC0);
    check("refill_stall", 32'(stall), 32'd0);
    drive(1'b1, 1'b0, 32'h74, 32'hD0);
    check("fst_stall", 32'(stall), 32'd1);
    check("fst_mem_addr", mem_addr, 32'h44);
    check("fst_mem_wdata", mem_wdata, 32'h1001);
    drive(1'b1, 1'b1, 32'h74, 32'hD0);
    check("fst_held_stall", 32'(stall), 32'd0);
    check("fst_held_we", 32'(mem_we), 32'd0);
    drive(1'b0, 1'b1, 32'h4c, 32'h0);
    check("refull_stall", 32'(stall), 32'd1);
    check("refull_addr", mem_addr, 32'h48);
    drive(1'b0, 1'b1, 32'h4c, 32'h0);
    check("fwd4c_stall", 32'(stall), 32'd0);
    check("fwd4c_rdata", cpu_rdata, 32'h1003);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("wrap_d0_addr", mem_addr, 32'h4c);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("wrap_d1_addr", mem_addr, 32'h70);
    check("wrap_d1_data", mem_wdata, 32'hC0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("wrap_d2_addr", mem_addr, 32'h74);
    check("wrap_d2_data", mem_wdata, 32'hD0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_mem70", mem[28], 32'hC0);
    check("wrap_mem74", mem[29], 32'hD0);
    check("wrap_mem48", mem[18], 32'h1002);

    // Duplicate stores: newest value forwarded and left in memory.
    drive(1'b1, 1'b1, 32'h58, 32'hA);
    drive(1'b1, 1'b1, 32'h58, 32'hB);
    check("dup_fwd_old", cpu_rdata, 32'hA);
    drive(1'b0, 1'b1, 32'h58, 32'h0);
    check("dup_fwd_new", cpu_rdata, 32'hB);
    check("dup_no_drain", 32'(mem_we), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("dup_d0_data", mem_wdata, 32'hA);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("dup_d1_data", mem_wdata, 32'hB);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("dup_empty", 32'(empty), 32'd1);
    check("dup_mem58", mem[22], 32'hB);

    // Load miss reads memory.
    drive(1'b0, 1'b1, 32'h5c, 32'h0);
    check("miss_rdata", cpu_rdata, 32'h115);
    check("miss_mem_we", 32'(mem_we), 32'd0);
    check("miss_mem_addr", mem_addr, 32'h5c);

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pl_exc_store_buf.md
Name: pl_exc_store_buf

Overview:
- Word-wide store buffer in the MEM stage of the exception-capable pipelined CPU, directly upstream of the data memory.
- Queues pipeline stores and drains them to the data memory one word per cycle.
- Loads forward data from pending stores. A load reads memory only when no pending store to the same word exists.
- The memory has a single address port with combinational read and clocked write. This block arbitrates the address between pipeline loads and buffer drains.

Parameters:
- DEPTH, 4, number of buffer entries (power of 2, at least 2)
- AW, 5, word-address bits compared and passed to memory (addr[AW+1:2])

Ports:
- clk  in  1  clock, all state updates on posedge
- clrn  in  1  reset, asynchronous, active-low
- cpu_we  in  1  store request from MEM stage
- cpu_re  in  1  load request from MEM stage
- cpu_addr  in  32  byte address, word-aligned
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, combinational
- stall  out  1  pipeline stall request, combinational
- empty  out  1  buffer holds no pending stores
- mem_we  out  1  data-memory write enable
- mem_addr  out  32  data-memory byte address
- mem_wdata  out  32  data-memory write data
- mem_rdata  in  32  data-memory read data, combinational from mem_addr

Behaviour:
- State:
  - circular FIFO of DEPTH entries, each holding {waddr[AW-1:0], data[31:0]}
  - head and tail pointers, log2(DEPTH) bits, wrap modulo DEPTH
  - count, log2(DEPTH)+1 bits
- Reset (clrn=0, asynchronous):
  - head, tail and count cleared to 0
  - empty=1, mem_we=0, stall=0 (with cpu_we=0)
  - entry contents are don't-care
- Definitions:
  - full = (count==DEPTH)
  - drain = ~empty & (full | ~cpu_re)
  - a drained full buffer has priority over loads
- stall = (cpu_we & full) | (cpu_re & full)
  - A stalled request is not accepted and must be held by the pipeline.
  - stall is asserted even in the cycle a drain frees an entry. The request is accepted on the next cycle.
- Memory port, combinational:
  - if drain: mem_we=1, mem_addr={0, head.waddr, 2'b00}, mem_wdata=head.data
  - else: mem_we=0, mem_addr=cpu_addr, mem_wdata=0
- Load forwarding, combinational, when cpu_re & ~stall:
  - search all valid entries for waddr==cpu_addr[AW+1:2]
  - on a hit, cpu_rdata = data of the newest matching entry (closest to tail)
  - on a miss, cpu_rdata = mem_rdata
  - a store presented in the same cycle is not visible to the load
- Store accept, posedge, when cpu_we & ~stall:
  - entry[tail] <= {cpu_addr[AW+1:2], cpu_wdata}
  - tail <= tail+1
- Drain, posedge, when drain: head <= head+1. The memory write occurs on the same edge.
- Count update: count <= count + accept − drain. Simultaneous accept and drain leaves count unchanged.
- Simultaneous load and store (cpu_re & cpu_we, not full):
  - load served first, store enqueued
  - no drain that cycle unless full
- Duplicate addresses:
  - multiple entries to the same word are allowed
  - drained in FIFO order, so memory ends with the newest value
- Latency:
  - store reaches memory at least 1 cycle after acceptance
  - load result is valid in the same cycle
- empty = (count==0), registered-state derived, no glitch on inputs.
- Reset mid-operation discards pending stores. Memory keeps only words already drained.
- cpu_addr[1:0] is ignored. Address bits above AW+1 are not compared and are driven 0 to memory on drains.

Test Plan:
- Reset, then idle with cpu_we=cpu_re=0 -> empty=1, mem_we=0, stall=0. An earlier cycle with clrn pulsed low mid-drain -> count=0 immediately, no further writes.
- Store 0x50 <- 0x11111111, then idle -> next cycle mem_we=1, mem_addr=0x50, mem_wdata=0x11111111. Following cycle empty=1.
- Continuous loads from 0x54 while 4 stores (0x40..0x4c) are pending -> full, so one load cycle sees stall=1 and a drain occurs. No stall on the next cycle.
- Back-to-back stores 0x58 <- 0xA, 0x58 <- 0xB, then load 0x58 while both are pending -> cpu_rdata=0xB. After draining, memory word 0x58 = 0xB.
- Load 0x5c with no match, memory holding 0x115 -> cpu_rdata=0x115, mem_we=0, mem_addr=0x5c.
- Full buffer plus a new store -> stall=1 for exactly 1 cycle. Store accepted on the next edge. count goes 4 -> 3 -> 4. Pointers wrap head/tail 3->0 correctly.
